// File: rtl/corrimiento_l_norm_pkg.sv
// Shared single-precision field widths, pack constants and normalizer FSM states.
package corrimiento_l_norm_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int SUM_W = 25;

  localparam logic [EXP_W-1:0] EXP_MAX     = 8'hFF;
  localparam logic [31:0]      FP_POS_ZERO = 32'h0000_0000;
  localparam logic [30:0]      FP_INF_MAG  = 31'h7F80_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EVAL  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } norm_state_t;

  function automatic logic [31:0] pack_fp(input logic s,
                                          input logic [EXP_W-1:0] e,
                                          input logic [MAN_W-1:0] f);
    return {s, e, f};
  endfunction

endpackage

// File: rtl/corrimiento_l_norm.sv
// Post-addition normalizer: one right shift on carry-out, otherwise one left
// shift per cycle until the hidden bit is set, then packs an IEEE-754 single.
module corrimiento_l_norm
  import corrimiento_l_norm_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sign_in,
  input  logic [EXP_W-1:0] exp_in,
  input  logic [SUM_W-1:0] man_in,
  output logic             busy,
  output logic             done,
  output logic [31:0]      result,
  output logic             ovf,
  output logic             unf
);

  norm_state_t      state_q, state_d;
  logic             sign_q, sign_d;
  logic [EXP_W-1:0] exp_q, exp_d;
  logic [SUM_W-1:0] man_q, man_d;
  logic [31:0]      result_d;
  logic             ovf_d, unf_d;
  logic             res_load;

  logic [SUM_W-1:0] man_rsh, man_lsh;
  logic [EXP_W-1:0] exp_inc, exp_dec;

  assign man_rsh = man_q >> 1;
  assign man_lsh = man_q << 1;
  assign exp_inc = exp_q + 8'd1;
  assign exp_dec = exp_q - 8'd1;

  // NOTE: every output of this block gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    man_d    = man_q;
    result_d = result;
    ovf_d    = 1'b0;
    unf_d    = 1'b0;
    res_load = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          sign_d  = sign_in;
          exp_d   = exp_in;
          man_d   = man_in;
          state_d = EVAL;
        end
      end

      EVAL: begin
        state_d  = DONE;
        res_load = 1'b1;
        if (exp_q == EXP_MAX) begin
          result_d = {sign_q, FP_INF_MAG};
          ovf_d    = 1'b1;
        end else if (man_q == '0) begin
          result_d = FP_POS_ZERO;
        end else if (exp_q == '0) begin
          result_d = {sign_q, 31'h0};
          unf_d    = 1'b1;
        end else if (man_q[SUM_W-1]) begin
          man_d = man_rsh;
          exp_d = exp_inc;
          if (exp_inc == EXP_MAX) begin
            result_d = {sign_q, FP_INF_MAG};
            ovf_d    = 1'b1;
          end else begin
            result_d = pack_fp(sign_q, exp_inc, man_rsh[MAN_W-1:0]);
          end
        end else if (man_q[MAN_W]) begin
          result_d = pack_fp(sign_q, exp_q, man_q[MAN_W-1:0]);
        end else begin
          // Hidden bit clear: hand off to the one-bit-per-cycle left shifter.
          state_d  = SHIFT;
          res_load = 1'b0;
        end
      end

      SHIFT: begin
        man_d = man_lsh;
        exp_d = exp_dec;
        if (exp_dec == '0 && !man_lsh[MAN_W]) begin
          result_d = {sign_q, 31'h0};
          unf_d    = 1'b1;
          res_load = 1'b1;
          state_d  = DONE;
        end else if (man_lsh[MAN_W]) begin
          result_d = pack_fp(sign_q, exp_dec, man_lsh[MAN_W-1:0]);
          res_load = 1'b1;
          state_d  = DONE;
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; the synchronous reset clears all of them, including
  // the working registers, so an aborted operation leaves nothing behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      man_q   <= '0;
      result  <= '0;
      ovf     <= 1'b0;
      unf     <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      man_q   <= man_d;
      if (res_load) begin
        result <= result_d;
        ovf    <= ovf_d;
        unf    <= unf_d;
      end
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

endmodule
